// File: rtl/mem_responder_if.sv
// Core/loader-facing bus of the memory responder.
// The core side drives requests and loader bytes; the responder returns
// read data and loader flow control.
interface mem_responder_if;
    logic        MemWrite;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;

    modport master (
        output MemWrite, Adr, WriteData, load_valid, load_byte,
        input  ReadData, load_ready
    );

    modport slave (
        input  MemWrite, Adr, WriteData, load_valid, load_byte,
        output ReadData, load_ready
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle ARM core.
// Serves a word-addressed RAM, an output register and a cycle counter,
// and runs a byte-serial boot loader that holds the core in reset until
// the RAM image has been received.
module mem_responder #(
    parameter int DEPTH_WORDS    = 64,
    parameter bit BOOT_PRELOADED = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    mem_responder_if.slave   bus,
    output logic             cpu_reset,
    output logic [31:0]      io_out,
    output logic             err
);

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [30:0] DEPTH_W  = 31'(DEPTH_WORDS);
    localparam logic [31:0] IO_ADDR  = 32'hFFFF_FFF0;
    localparam logic [31:0] CNT_ADDR = 32'hFFFF_FFF4;

    typedef enum logic [1:0] {
        CNT_HI,
        CNT_LO,
        WORD,
        RUN
    } state_t;

    state_t      state;
    logic [15:0] count;
    logic [1:0]  byte_idx;
    logic [15:0] word_idx;
    logic [23:0] shift_reg;
    logic [31:0] cycle_cnt;

    logic [31:0] ram [DEPTH_WORDS];

    logic          in_ram;
    logic          is_io;
    logic          is_cnt;
    logic [AW-1:0] core_idx;
    logic [AW-1:0] load_idx;
    logic          core_wr;
    logic          byte_fire;
    logic          word_done;
    logic          load_in_range;
    logic          last_word;
    logic [31:0]   assembled;

    assign in_ram        = ({1'b0, bus.Adr[31:2]} < DEPTH_W);
    assign is_io         = (bus.Adr == IO_ADDR);
    assign is_cnt        = (bus.Adr == CNT_ADDR);
    assign core_idx      = bus.Adr[AW+1:2];
    assign load_idx      = word_idx[AW-1:0];
    assign core_wr       = bus.MemWrite && !cpu_reset;
    assign byte_fire     = bus.load_valid && bus.load_ready;
    assign word_done     = byte_fire && (state == WORD) && (byte_idx == 2'd3);
    assign load_in_range = ({15'd0, word_idx} < DEPTH_W);
    assign last_word     = (({1'b0, word_idx} + 17'd1) == {1'b0, count});
    assign assembled     = {shift_reg, bus.load_byte};

    // Boot loader FSM: collects the word count and big-endian words, then parks in RUN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= BOOT_PRELOADED ? RUN : CNT_HI;
            cpu_reset      <= !BOOT_PRELOADED;
            bus.load_ready <= !BOOT_PRELOADED;
            count          <= 16'd0;
            byte_idx       <= 2'd0;
            word_idx       <= 16'd0;
            shift_reg      <= 24'd0;
        end else begin
            case (state)
                CNT_HI: begin
                    if (byte_fire) begin
                        count[15:8] <= bus.load_byte;
                        state       <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (byte_fire) begin
                        count[7:0] <= bus.load_byte;
                        if ({count[15:8], bus.load_byte} == 16'd0) begin
                            state          <= RUN;
                            cpu_reset      <= 1'b0;
                            bus.load_ready <= 1'b0;
                        end else begin
                            state <= WORD;
                        end
                    end
                end
                WORD: begin
                    if (byte_fire) begin
                        shift_reg <= {shift_reg[15:0], bus.load_byte};
                        byte_idx  <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            word_idx <= word_idx + 16'd1;
                            if (last_word) begin
                                state          <= RUN;
                                cpu_reset      <= 1'b0;
                                bus.load_ready <= 1'b0;
                            end
                        end
                    end
                end
                RUN: begin
                end
                default: begin
                    state <= CNT_HI;
                end
            endcase
        end
    end

    // Cycle counter: zero on the first RUN cycle, free-running while in RUN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= 32'd0;
        end else if (state == RUN) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end else begin
            cycle_cnt <= 32'd0;
        end
    end

    // Output register writes and the sticky error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_out <= 32'd0;
            err    <= 1'b0;
        end else begin
            if (core_wr && is_io) begin
                io_out <= bus.WriteData;
            end
            if (core_wr && !in_ram && !is_io) begin
                err <= 1'b1;
            end
            if (word_done && !load_in_range) begin
                err <= 1'b1;
            end
        end
    end

    // RAM write port, shared by the loader and the core (never active together)
    always_ff @(posedge clk) begin
        if (word_done && load_in_range) begin
            ram[load_idx] <= assembled;
        end else if (core_wr && in_ram) begin
            ram[core_idx] <= bus.WriteData;
        end
    end

    // Combinational read mux over the address map
    always_comb begin
        bus.ReadData = 32'd0;
        if (in_ram) begin
            bus.ReadData = ram[core_idx];
        end else if (is_io) begin
            bus.ReadData = io_out;
        end else if (is_cnt) begin
            bus.ReadData = cycle_cnt;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a byte-level model of the loader
// and address map is compared against the design every cycle, with a few
// literal expectations from the boot scenarios.
module tb_mem_responder;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] IO_ADDR  = 32'hFFFF_FFF0;
    localparam logic [31:0] CNT_ADDR = 32'hFFFF_FFF4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_reset;
    logic [31:0] io_out;
    logic        err;

    mem_responder_if bus();

    mem_responder #(
        .DEPTH_WORDS    (DEPTH),
        .BOOT_PRELOADED (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .cpu_reset (cpu_reset),
        .io_out    (io_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit loadRand = 1'b1;

    // Reference model state: bytes accepted so far, expected image and registers
    int          mAccepted = 0;
    logic [15:0] mCount    = 16'd0;
    bit          mRun      = 1'b0;
    logic [31:0] mIo       = 32'd0;
    logic [31:0] mCnt      = 32'd0;
    bit          mErr      = 1'b0;
    logic [31:0] mPartial  = 32'd0;
    logic [31:0] mRam   [DEPTH];
    bit          mValid [DEPTH] = '{default: 1'b0};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Model update: the loader consumes the byte stream, the core sees the address map once running
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mAccepted = 0;
            mCount    = 16'd0;
            mRun      = 1'b0;
            mIo       = 32'd0;
            mCnt      = 32'd0;
            mErr      = 1'b0;
            mPartial  = 32'd0;
        end else if (mRun) begin
            if (bus.MemWrite) begin
                int w;
                w = int'({2'b00, bus.Adr[31:2]});
                if (w < DEPTH) begin
                    mRam[w]   = bus.WriteData;
                    mValid[w] = 1'b1;
                end else if (bus.Adr == IO_ADDR) begin
                    mIo = bus.WriteData;
                end else begin
                    mErr = 1'b1;
                end
            end
            mCnt = mCnt + 32'd1;
        end else if (bus.load_valid) begin
            mAccepted++;
            if (mAccepted == 1) begin
                mCount[15:8] = bus.load_byte;
            end else if (mAccepted == 2) begin
                mCount[7:0] = bus.load_byte;
                if (mCount == 16'd0) mRun = 1'b1;
            end else begin
                mPartial = {mPartial[23:0], bus.load_byte};
                if ((mAccepted - 2) % 4 == 0) begin
                    int k;
                    k = (mAccepted - 2) / 4 - 1;
                    if (k < DEPTH) begin
                        mRam[k]   = mPartial;
                        mValid[k] = 1'b1;
                    end else begin
                        mErr = 1'b1;
                    end
                    if (k + 1 == int'({16'd0, mCount})) mRun = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        int w;
        checkOutput("load_ready", 32'(bus.load_ready), 32'(!mRun));
        checkOutput("cpu_reset", 32'(cpu_reset), 32'(!mRun));
        checkOutput("io_out", io_out, mIo);
        checkOutput("err", 32'(err), 32'(mErr));
        w = int'({2'b00, bus.Adr[31:2]});
        if (w < DEPTH) begin
            if (mValid[w]) checkOutput("ReadData_ram", bus.ReadData, mRam[w]);
        end else if (bus.Adr == IO_ADDR) begin
            checkOutput("ReadData_io", bus.ReadData, mIo);
        end else if (bus.Adr == CNT_ADDR) begin
            checkOutput("ReadData_cnt", bus.ReadData, mCnt);
        end else begin
            checkOutput("ReadData_unmapped", bus.ReadData, 32'd0);
        end
    end

    task automatic randomCoreOp();
        case ($urandom_range(0, 3))
            0:       bus.Adr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
            1:       bus.Adr = IO_ADDR;
            2:       bus.Adr = CNT_ADDR;
            default: bus.Adr = $urandom;
        endcase
        bus.MemWrite  = 1'($urandom_range(0, 1));
        bus.WriteData = $urandom;
    endtask

    // One clock step; core requests are scrambled while loading to prove they are ignored
    task automatic applyStimulus();
        @(negedge clk);
        #1;
        if (!mRun && loadRand) randomCoreOp();
        else bus.MemWrite = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            bus.load_valid = 1'b0;
            applyStimulus();
        end
        n = 0;
        while (!bus.load_ready && n < 20) begin
            applyStimulus();
            n++;
        end
        if (!bus.load_ready) checkOutput("load_ready_timeout", 32'(bus.load_ready), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_byte  = b;
        applyStimulus();
        bus.load_valid = 1'b0;
    endtask

    // gapMode: 0 continuous, 1 alternate cycles, 2 random gaps
    task automatic loadImage(input logic [15:0] cnt, input logic [31:0] words[$], input int gapMode);
        logic [7:0] bytes[$];
        bytes.push_back(cnt[15:8]);
        bytes.push_back(cnt[7:0]);
        foreach (words[i]) begin
            logic [31:0] wv;
            wv = words[i];
            bytes.push_back(wv[31:24]);
            bytes.push_back(wv[23:16]);
            bytes.push_back(wv[15:8]);
            bytes.push_back(wv[7:0]);
        end
        foreach (bytes[i]) begin
            int gap;
            gap = (gapMode == 0) ? 0 : (gapMode == 1) ? 1 : int'($urandom_range(0, 2));
            sendByte(bytes[i], (i == 0) ? 0 : gap);
        end
    endtask

    task automatic doReset();
        bus.load_valid = 1'b0;
        bus.MemWrite   = 1'b0;
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        applyStimulus();
    endtask

    task automatic readLiteral(input string name, input logic [31:0] adr, input logic [31:0] expected);
        bus.MemWrite = 1'b0;
        bus.Adr      = adr;
        #1;
        checkOutput(name, bus.ReadData, expected);
    endtask

    task automatic coreWrite(input logic [31:0] adr, input logic [31:0] data);
        bus.Adr       = adr;
        bus.WriteData = data;
        bus.MemWrite  = 1'b1;
        applyStimulus();
        bus.MemWrite  = 1'b0;
    endtask

    task automatic runRandom(input int cycles);
        repeat (cycles) begin
            applyStimulus();
            randomCoreOp();
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.load_byte  = 8'($urandom);
        end
        applyStimulus();
        bus.load_valid = 1'b0;
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] img2[$];
        logic [31:0] ovf[$];
        logic [31:0] fresh[$];
        logic [31:0] none[$];
        img2  = '{32'hE3A0_0005, 32'hE280_0001};
        ovf   = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003, 32'h5555_0004};
        fresh = '{32'hA5A5_0001, 32'h5A5A_0002};

        bus.MemWrite   = 1'b0;
        bus.Adr        = 32'd0;
        bus.WriteData  = 32'd0;
        bus.load_valid = 1'b0;
        bus.load_byte  = 8'd0;
        #1;
        reset = 1'b1;
        applyStimulus();
        checkOutput("reset_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("reset_load_ready", 32'(bus.load_ready), 32'd1);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_io_out", io_out, 32'd0);
        reset = 1'b0;
        applyStimulus();

        $display("[TB] continuous load of two words");
        loadImage(16'd2, img2, 0);
        loadRand = 1'b0;
        checkOutput("load1_cpu_reset", 32'(cpu_reset), 32'd0);
        checkOutput("load1_load_ready", 32'(bus.load_ready), 32'd0);
        checkOutput("load1_err", 32'(err), 32'd0);
        readLiteral("load1_word0", 32'd0, 32'hE3A0_0005);
        readLiteral("load1_word1", 32'd4, 32'hE280_0001);
        coreWrite(IO_ADDR, 32'h0000_1234);
        checkOutput("io_write", io_out, 32'h0000_1234);
        checkOutput("io_write_err", 32'(err), 32'd0);
        coreWrite(CNT_ADDR, 32'hDEAD_BEEF);
        checkOutput("cnt_write_err", 32'(err), 32'd1);
        runRandom(150);

        $display("[TB] gapped load of the same image");
        loadRand = 1'b1;
        doReset();
        loadImage(16'd2, img2, 1);
        loadRand = 1'b0;
        readLiteral("load2_word0", 32'd0, 32'hE3A0_0005);
        readLiteral("load2_word1", 32'd4, 32'hE280_0001);
        checkOutput("load2_err", 32'(err), 32'd0);

        $display("[TB] zero-length image");
        loadRand = 1'b1;
        doReset();
        loadImage(16'd0, none, 0);
        loadRand = 1'b0;
        checkOutput("zero_cpu_reset", 32'(cpu_reset), 32'd0);
        checkOutput("zero_err", 32'(err), 32'd0);
        readLiteral("cnt_first_run_cycle", CNT_ADDR, 32'd0);
        applyStimulus();
        readLiteral("cnt_after_1", CNT_ADDR, 32'd1);
        repeat (3) applyStimulus();
        readLiteral("cnt_after_4", CNT_ADDR, 32'd4);

        $display("[TB] overflowing image");
        loadRand = 1'b1;
        doReset();
        loadImage(16'd5, ovf, 2);
        loadRand = 1'b0;
        checkOutput("ovf_err", 32'(err), 32'd1);
        checkOutput("ovf_cpu_reset", 32'(cpu_reset), 32'd0);
        readLiteral("ovf_word0", 32'd0, 32'h1111_0000);
        readLiteral("ovf_word3", 32'd12, 32'h4444_0003);
        readLiteral("ovf_word4_unmapped", 32'd16, 32'd0);
        runRandom(100);

        $display("[TB] reset in the middle of a load");
        loadRand = 1'b1;
        doReset();
        sendByte(8'h00, 0);
        sendByte(8'h02, 0);
        sendByte(8'hCA, 0);
        sendByte(8'hFE, 0);
        sendByte(8'hF0, 0);
        sendByte(8'h0D, 0);
        loadRand = 1'b0;
        readLiteral("midload_word0", 32'd0, 32'hCAFE_F00D);
        doReset();
        checkOutput("midreset_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("midreset_load_ready", 32'(bus.load_ready), 32'd1);
        readLiteral("midreset_word0_kept", 32'd0, 32'hCAFE_F00D);
        loadRand = 1'b1;
        loadImage(16'd2, fresh, 2);
        loadRand = 1'b0;
        readLiteral("fresh_word0", 32'd0, 32'hA5A5_0001);
        readLiteral("fresh_word1", 32'd4, 32'h5A5A_0002);
        checkOutput("fresh_cpu_reset", 32'(cpu_reset), 32'd0);
        runRandom(150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
